// File: rtl/onebyfour_demux_reg_if.sv
// Bus bundle for the registered 1-to-4 demultiplexer.
// It carries the input stream, the routing controls, the four output
// channels with their handshakes, and the status outputs.
interface onebyfour_demux_reg_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] a;
  logic             a_valid;
  logic             a_ready;
  logic             s0;
  logic             s1;
  logic             auto_rr;
  logic [WIDTH-1:0] ya;
  logic [WIDTH-1:0] yb;
  logic [WIDTH-1:0] yc;
  logic [WIDTH-1:0] yd;
  logic             ya_valid;
  logic             yb_valid;
  logic             yc_valid;
  logic             yd_valid;
  logic             ya_ready;
  logic             yb_ready;
  logic             yc_ready;
  logic             yd_ready;
  logic [1:0]       rr_ptr;
  logic [CNT_W-1:0] beat_cnt;

  // Producer/consumer side: drives the stream, the controls and the channel readies.
  modport master (
    output a, a_valid, s0, s1, auto_rr,
    output ya_ready, yb_ready, yc_ready, yd_ready,
    input  a_ready,
    input  ya, yb, yc, yd,
    input  ya_valid, yb_valid, yc_valid, yd_valid,
    input  rr_ptr, beat_cnt
  );

  // Demultiplexer side.
  modport slave (
    input  a, a_valid, s0, s1, auto_rr,
    input  ya_ready, yb_ready, yc_ready, yd_ready,
    output a_ready,
    output ya, yb, yc, yd,
    output ya_valid, yb_valid, yc_valid, yd_valid,
    output rr_ptr, beat_cnt
  );
endinterface

// File: rtl/onebyfour_demux_reg.sv
// Registered 1-to-4 demultiplexer.
// One input stream is steered to one of four channels, chosen either by
// {s1,s0} or by a round-robin pointer. Each channel owns a one-entry
// register with a valid/ready handshake, so a stalled consumer only blocks
// beats aimed at its own channel. All outputs come straight from registers;
// only a_ready is combinational.
module onebyfour_demux_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input logic                  clk,
  input logic                  rst,
  onebyfour_demux_reg_if.slave bus
);

  logic [WIDTH-1:0] data_r [4];
  logic [3:0]       valid_r;
  logic [1:0]       rr_ptr_r;
  logic [CNT_W-1:0] beat_cnt_r;

  logic [3:0]       ready_s;
  logic [1:0]       target_s;
  logic             a_ready_s;
  logic             accept_s;

  // Target channel and input handshake, looking only at the target channel.
  always_comb begin
    ready_s   = {bus.yd_ready, bus.yc_ready, bus.yb_ready, bus.ya_ready};
    target_s  = 2'd0;
    a_ready_s = 1'b0;
    if (bus.auto_rr) begin
      target_s = rr_ptr_r;
    end else begin
      target_s = {bus.s1, bus.s0};
    end
    if (rst) begin
      a_ready_s = 1'b0;
    end else begin
      a_ready_s = !valid_r[target_s] || ready_s[target_s];
    end
    accept_s = bus.a_valid && a_ready_s;
  end

  // Channel registers: load on accept, clear on drain, otherwise hold.
  // A drain and an accept on the same channel keep it full with the new beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        data_r[k] <= {WIDTH{1'b0}};
      end
      valid_r <= 4'b0000;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (accept_s && (target_s == 2'(k))) begin
          data_r[k]  <= bus.a;
          valid_r[k] <= 1'b1;
        end else if (valid_r[k] && ready_s[k]) begin
          valid_r[k] <= 1'b0;
        end else begin
          valid_r[k] <= valid_r[k];
        end
      end
    end
  end

  // Beat counter and round-robin pointer; the pointer only moves on an
  // accepted beat in round-robin mode and is retained across manual periods.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_r <= {CNT_W{1'b0}};
      rr_ptr_r   <= 2'd0;
    end else begin
      if (accept_s) begin
        beat_cnt_r <= beat_cnt_r + CNT_W'(1);
      end else begin
        beat_cnt_r <= beat_cnt_r;
      end
      if (accept_s && bus.auto_rr) begin
        rr_ptr_r <= rr_ptr_r + 2'd1;
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end
    end
  end

  assign bus.a_ready  = a_ready_s;
  assign bus.ya       = data_r[0];
  assign bus.yb       = data_r[1];
  assign bus.yc       = data_r[2];
  assign bus.yd       = data_r[3];
  assign bus.ya_valid = valid_r[0];
  assign bus.yb_valid = valid_r[1];
  assign bus.yc_valid = valid_r[2];
  assign bus.yd_valid = valid_r[3];
  assign bus.rr_ptr   = rr_ptr_r;
  assign bus.beat_cnt = beat_cnt_r;

endmodule

// File: tb/tb_onebyfour_demux_reg.sv
// Directed self-checking bench for onebyfour_demux_reg.
// Inputs change 1 time unit after a rising edge; registered outputs are
// checked at the same point, and a_ready is checked 1 unit after the inputs.
module tb_onebyfour_demux_reg;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  onebyfour_demux_reg_if #(.WIDTH(8), .CNT_W(8)) bus ();

  onebyfour_demux_reg #(.WIDTH(8), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] y_data [4];
  logic [3:0] y_valid;

  // Index view of the four channels.
  always_comb begin
    y_data[0] = bus.ya;
    y_data[1] = bus.yb;
    y_data[2] = bus.yc;
    y_data[3] = bus.yd;
    y_valid   = {bus.yd_valid, bus.yc_valid, bus.yb_valid, bus.ya_valid};
  end

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic [1:0] s, input logic rr);
    bus.a_valid = v;
    bus.a       = d;
    bus.s1      = s[1];
    bus.s0      = s[0];
    bus.auto_rr = rr;
  endtask

  task automatic set_ready(input logic [3:0] r);
    bus.ya_ready = r[0];
    bus.yb_ready = r[1];
    bus.yc_ready = r[2];
    bus.yd_ready = r[3];
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;

    // Reset with a beat being offered.
    rst = 1'b1;
    set_ready(4'b1111);
    drive(1'b1, 8'hFF, 2'd0, 1'b0);
    tick();
    tick();
    check("rst_valids", {28'd0, y_valid}, 32'h0);
    check("rst_ya", {24'd0, y_data[0]}, 32'h0);
    check("rst_yd", {24'd0, y_data[3]}, 32'h0);
    check("rst_rr", {30'd0, bus.rr_ptr}, 32'h0);
    check("rst_cnt", {24'd0, bus.beat_cnt}, 32'h0);
    check("rst_a_ready", {31'd0, bus.a_ready}, 32'h0);

    rst = 1'b0;
    drive(1'b0, 8'hAB, 2'd0, 1'b0);
    tick();
    check("idle_no_load", {24'd0, y_data[0]}, 32'h0);

    // Manual routing, one beat per channel.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'(8'h11 * (i + 1)), 2'(i), 1'b0);
      #1;
      check("man_a_ready", {31'd0, bus.a_ready}, 32'h1);
      tick();
      check("man_valid", {31'd0, y_valid[i]}, 32'h1);
      check("man_data", {24'd0, y_data[i]}, 32'(8'h11 * (i + 1)));
      if (i > 0) begin
        check("man_prev_drained", {31'd0, y_valid[i-1]}, 32'h0);
      end else begin
        check("man_others_empty", {28'd0, y_valid}, 32'h1);
      end
    end
    drive(1'b0, 8'h00, 2'd0, 1'b0);
    tick();
    check("man_yd_drained", {31'd0, y_valid[3]}, 32'h0);
    check("man_cnt", {24'd0, bus.beat_cnt}, 32'd4);
    check("man_rr", {30'd0, bus.rr_ptr}, 32'd0);

    // Stall isolation on channel 1.
    set_ready(4'b1101);
    drive(1'b1, 8'hA5, 2'd1, 1'b0);
    #1;
    check("stall_first_ready", {31'd0, bus.a_ready}, 32'h1);
    tick();
    check("stall_yb_a5", {23'd0, y_valid[1], y_data[1]}, 32'h1A5);
    drive(1'b1, 8'h5A, 2'd1, 1'b0);
    #1;
    check("stall_second_blocked", {31'd0, bus.a_ready}, 32'h0);
    tick();
    check("stall_yb_hold", {23'd0, y_valid[1], y_data[1]}, 32'h1A5);
    drive(1'b1, 8'h77, 2'd3, 1'b0);
    #1;
    check("stall_other_ready", {31'd0, bus.a_ready}, 32'h1);
    tick();
    check("stall_yd_77", {23'd0, y_valid[3], y_data[3]}, 32'h177);
    check("stall_yb_still", {23'd0, y_valid[1], y_data[1]}, 32'h1A5);
    set_ready(4'b1111);
    drive(1'b1, 8'h5A, 2'd1, 1'b0);
    #1;
    check("stall_release_ready", {31'd0, bus.a_ready}, 32'h1);
    tick();
    check("stall_yb_5a", {23'd0, y_valid[1], y_data[1]}, 32'h15A);
    drive(1'b0, 8'h00, 2'd0, 1'b0);
    tick();
    check("stall_yb_drained", {31'd0, y_valid[1]}, 32'h0);
    check("stall_cnt", {24'd0, bus.beat_cnt}, 32'd7);

    // Round-robin over six beats; select lines left X to show they are ignored.
    for (int i = 1; i <= 6; i++) begin
      drive(1'b1, 8'(i), 2'bxx, 1'b1);
      #1;
      check("rr_a_ready", {31'd0, bus.a_ready}, 32'h1);
      tick();
      check("rr_data", {23'd0, y_valid[(i-1)%4], y_data[(i-1)%4]}, 32'h100 + 32'(i));
    end
    check("rr_ptr_end", {30'd0, bus.rr_ptr}, 32'd2);

    // Fill yc manually with it stalled, then return to round-robin at pointer 2.
    set_ready(4'b1011);
    drive(1'b1, 8'hC3, 2'd2, 1'b0);
    tick();
    check("rr_yc_full", {23'd0, y_valid[2], y_data[2]}, 32'h1C3);
    check("rr_ptr_manual_hold", {30'd0, bus.rr_ptr}, 32'd2);
    drive(1'b1, 8'h99, 2'd0, 1'b1);
    #1;
    check("rr_stall_ready", {31'd0, bus.a_ready}, 32'h0);
    tick();
    tick();
    check("rr_stall_ptr", {30'd0, bus.rr_ptr}, 32'd2);
    check("rr_stall_yc", {23'd0, y_valid[2], y_data[2]}, 32'h1C3);
    set_ready(4'b1111);
    #1;
    check("rr_release_ready", {31'd0, bus.a_ready}, 32'h1);
    tick();
    check("rr_yc_99", {23'd0, y_valid[2], y_data[2]}, 32'h199);
    check("rr_ptr_adv", {30'd0, bus.rr_ptr}, 32'd3);
    check("rr_cnt", {24'd0, bus.beat_cnt}, 32'd15);

    // Same-cycle drain and accept on channel 0, then ten back-to-back beats.
    drive(1'b1, 8'h10, 2'd0, 1'b0);
    tick();
    check("dr_ya_10", {23'd0, y_valid[0], y_data[0]}, 32'h110);
    drive(1'b1, 8'h20, 2'd0, 1'b0);
    #1;
    check("dr_ready_full", {31'd0, bus.a_ready}, 32'h1);
    tick();
    check("dr_ya_20", {23'd0, y_valid[0], y_data[0]}, 32'h120);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 8'(8'h30 + i), 2'd0, 1'b0);
      #1;
      check("b2b_ready", {31'd0, bus.a_ready}, 32'h1);
      tick();
      check("b2b_ya", {23'd0, y_valid[0], y_data[0]}, 32'h130 + 32'(i));
    end
    drive(1'b0, 8'h00, 2'd0, 1'b0);
    check("b2b_cnt", {24'd0, bus.beat_cnt}, 32'd27);
    check("b2b_rr_kept", {30'd0, bus.rr_ptr}, 32'd3);

    // Counter wrap: 229 more beats bring the total to 256.
    for (int i = 0; i < 229; i++) begin
      drive(1'b1, 8'(i), 2'(i), 1'b0);
      tick();
    end
    drive(1'b0, 8'h00, 2'd0, 1'b0);
    check("wrap_cnt", {24'd0, bus.beat_cnt}, 32'd0);

    // Reset mid-stream with yc full and an accept being offered.
    set_ready(4'b1011);
    drive(1'b1, 8'hEE, 2'd2, 1'b0);
    tick();
    check("mid_yc_full", {23'd0, y_valid[2], y_data[2]}, 32'h1EE);
    drive(1'b1, 8'hDD, 2'd3, 1'b0);
    rst = 1'b1;
    #1;
    check("mid_rst_ready", {31'd0, bus.a_ready}, 32'h0);
    tick();
    check("mid_valids", {28'd0, y_valid}, 32'h0);
    check("mid_yd", {24'd0, y_data[3]}, 32'h0);
    check("mid_cnt", {24'd0, bus.beat_cnt}, 32'h0);
    check("mid_rr", {30'd0, bus.rr_ptr}, 32'h0);
    rst = 1'b0;
    drive(1'b0, 8'h00, 2'd0, 1'b0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/onebyfour_demux_reg.md
Name: onebyfour_demux_reg

Overview:
- Registered 1-to-4 demultiplexer: the distribution counterpart to the four-to-one CMOS mux tree.
- Routes a single input stream to one of four output channels.
- Target channel comes from select lines s1,s0, or from an internal round-robin pointer.
- Each output has a one-entry skid register with valid/ready handshake, so slow consumers stall only their own channel.
- Used where one shared datapath fans out to four downstream units.

Parameters:
- WIDTH, 8, data width of input and each output channel.
- CNT_W, 8, width of the accepted-beat counter.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- a  input  WIDTH  input data.
- a_valid  input  1  input beat present.
- a_ready  output  1  input beat accepted this cycle when a_valid & a_ready.
- s0  input  1  channel select LSB (manual mode).
- s1  input  1  channel select MSB (manual mode).
- auto_rr  input  1  1 = round-robin routing, 0 = route by {s1,s0}.
- ya, yb, yc, yd  output  WIDTH  channel 0..3 data.
- ya_valid, yb_valid, yc_valid, yd_valid  output  1  channel 0..3 holds a beat.
- ya_ready, yb_ready, yc_ready, yd_ready  input  1  channel 0..3 consumer ready.
- rr_ptr  output  2  current round-robin pointer.
- beat_cnt  output  CNT_W  total accepted input beats, modulo 2^CNT_W.

Behaviour:
- Reset (rst=1 at a rising edge):
  - All y*_valid=0, all y* data=0, rr_ptr=0, beat_cnt=0.
  - rst overrides any simultaneous accept or drain; an in-flight beat is discarded.
  - a_ready is combinational and low during any cycle with rst=1.
- Target selection (combinational): t = auto_rr ? rr_ptr : {s1,s0}. Channel index mapping: 0=ya, 1=yb, 2=yc, 3=yd.
- Ready: a_ready = !rst & (!valid[t] | ready[t]). Depends only on the target channel; the other three channels' state is irrelevant.
- Accept (a_valid & a_ready):
  - Next edge: data[t]<=a, valid[t]<=1, beat_cnt<=beat_cnt+1 (wraps 2^CNT_W-1 -> 0).
  - Latency input-to-output is 1 cycle.
  - No combinational path from a to y*.
- Drain: valid[k] & ready[k] with no accept into k clears valid[k] next edge.
- Simultaneous drain and accept on the same channel: valid stays 1 and data is replaced by the new beat (full throughput, one beat per cycle per channel).
- Hold: while valid[k] & !ready[k], data[k] and valid[k] remain stable. They are never overwritten, because a_ready is low for that target.
- Round-robin:
  - rr_ptr advances (mod 4, 3 -> 0) only on an accepted beat while auto_rr=1.
  - It holds on stalls, idle cycles, and whenever auto_rr=0.
  - If the pointed channel is stalled, the block waits; there is no skipping to a free channel.
- Mode switch: a change of auto_rr or s1,s0 takes effect in the same cycle for target and a_ready. rr_ptr is retained across manual periods.
- Drains on non-target channels proceed independently in the same cycle as an accept elsewhere.
- X on s0/s1 is ignored when auto_rr=1. X on a is tolerated only while a_valid=0.

Test Plan:
- Reset: assert rst 2 cycles with a_valid=1, a=8'hFF -> all y*_valid=0, y*=0, rr_ptr=0, beat_cnt=0, a_ready=0.
- Manual routing: auto_rr=0, all y*_ready=1; send 8'h11,8'h22,8'h33,8'h44 with {s1,s0}=0,1,2,3 on consecutive cycles -> ya=11, yb=22, yc=33, yd=44, each valid exactly one cycle after its accept; beat_cnt=4; rr_ptr=0.
- Stall isolation: yb_ready=0, send 8'hA5 to channel 1 then 8'h5A to channel 1 -> a_ready=0 on the second beat, yb holds A5. Meanwhile send 8'h77 to channel 3 -> accepted, yd=77. Raise yb_ready -> A5 drains, then 5A accepted.
- Round-robin: auto_rr=1, all ready=1, 6 beats 8'h01..8'h06 -> ya=01, yb=02, yc=03, yd=04, ya=05, yb=06; rr_ptr=2 at end. Stall yc_ready=0 with yc full -> a_ready=0 and rr_ptr holds at 2.
- Same-cycle drain+accept: channel 0 full with 8'h10, ya_ready=1, accept 8'h20 to channel 0 -> ya_valid stays 1 and ya=20 next cycle. Back-to-back 10 beats at full rate show no bubble.
- Wrap and reset mid-stream: CNT_W=8, accept 256 beats -> beat_cnt=0. Assert rst while yc_valid=1 and an accept is in progress -> next cycle all valids=0, beat_cnt=0, rr_ptr=0.
